neuron_mac: RTL

Pre-activation stage of the neuron datapath: accumulates N_INPUTS signed Q8.8 input×weight products plus a Q8.8 bias. It then requantises the sum to a saturated 16-bit Q8.8 value `z_out`, which drives the `x` input of the sigmoid PWL stage directly downstream. Inputs arrive over a valid/ready stream and the result is held on a valid/ready output until consumed. One vector is processed at a time.

---
 rtl/neuron_pkg.sv | 17 +
 rtl/neuron_requant.sv | 37 +++
 rtl/neuron_mac.sv | 98 +++++++++
 3 files changed

// File: rtl/neuron_pkg.sv
// Q8.8 constants and the FSM state type for the neuron datapath.
// Shared by neuron_mac, neuron_requant and the downstream sigmoid stage.
package neuron_pkg;

    localparam int          DATA_W    = 16;
    localparam int          FRAC_BITS = 8;
    localparam logic [15:0] Q_MAX     = 16'h7FFF;
    localparam logic [15:0] Q_MIN     = 16'h8000;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        FIN,
        DONE
    } state_t;

endpackage

// File: rtl/neuron_requant.sv
// Requantises a Q(ACC_W-16).16 accumulator to saturated Q8.8.
// Build option: NEURON_MAC_ROUND_EN selects round-half-up; otherwise floor.
module neuron_requant
    import neuron_pkg::*;
#(
    parameter int ACC_W = 40
) (
    input  logic signed [ACC_W-1:0]  i_acc,
    output logic signed [DATA_W-1:0] o_z
);

`ifdef NEURON_MAC_ROUND_EN
    localparam logic signed [ACC_W-1:0] RND = ACC_W'(1) <<< (FRAC_BITS - 1);
`else
    localparam logic signed [ACC_W-1:0] RND = '0;
`endif

    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'($signed(Q_MAX));
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'($signed(Q_MIN));

    function automatic logic signed [DATA_W-1:0] sat(input logic signed [ACC_W-1:0] v);
        if (v > SAT_HI)
            return $signed(Q_MAX);
        else if (v < SAT_LO)
            return $signed(Q_MIN);
        else
            return v[DATA_W-1:0];
    endfunction

    logic signed [ACC_W-1:0] w_rnd;
    logic signed [ACC_W-1:0] w_shf;

    assign w_rnd = i_acc + RND;
    assign w_shf = w_rnd >>> FRAC_BITS;
    assign o_z   = sat(w_shf);

endmodule

// File: rtl/neuron_mac.sv
// Neuron pre-activation: bias + sum of N_INPUTS Q8.8 products, saturated to Q8.8.
// Rounding behaviour is set by NEURON_MAC_ROUND_EN inside neuron_requant.
module neuron_mac
    import neuron_pkg::*;
#(
    parameter int N_INPUTS = 16,
    parameter int ACC_W    = 40
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] x_in,
    input  logic signed [DATA_W-1:0] w_in,
    input  logic signed [DATA_W-1:0] bias_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] z_out
);

    localparam int CNT_W = $clog2(N_INPUTS + 1);

    state_t                    r_state;
    state_t                    w_next;
    logic [CNT_W-1:0]          r_cnt;
    logic signed [ACC_W-1:0]   r_acc;
    logic signed [DATA_W-1:0]  r_z;
    logic signed [DATA_W-1:0]  w_z;
    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W-1:0]   w_prod_ext;
    logic signed [ACC_W-1:0]   w_bias_ext;
    logic                      w_beat;
    logic                      w_last;

    // Q8.8 x Q8.8 gives Q16.16; bias is lifted to the same binary point.
    assign w_prod     = x_in * w_in;
    assign w_prod_ext = ACC_W'(w_prod);
    assign w_bias_ext = ACC_W'(bias_in) <<< FRAC_BITS;
    assign w_beat     = in_valid && in_ready;
    assign w_last     = (r_cnt == CNT_W'(N_INPUTS - 1));

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = rst;
                if (w_beat)
                    w_next = (N_INPUTS == 1) ? FIN : ACC;
            end
            ACC: begin
                in_ready = rst;
                if (w_beat && w_last)
                    w_next = FIN;
            end
            FIN: w_next = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_z     <= '0;
        end else begin
            r_state <= w_next;
            if (w_beat) begin
                if (r_state == IDLE) begin
                    r_acc <= w_bias_ext + w_prod_ext;
                    r_cnt <= CNT_W'(1);
                end else begin
                    r_acc <= r_acc + w_prod_ext;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
            if (r_state == FIN)
                r_z <= w_z;
        end
    end

    neuron_requant #(
        .ACC_W(ACC_W)
    ) u_requant (
        .i_acc(r_acc),
        .o_z  (w_z)
    );

    assign z_out = r_z;

endmodule
